// File: rtl/referee_pkg.sv
// Shared types and constants for the match referee: FSM states, winner codes
// and active-low 7-segment patterns ({g..a}, 0 = segment lit).
package referee_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    PAUSE = 2'd1,
    OVER  = 2'd2
  } ref_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

endpackage

// File: rtl/seg7_digit.sv
// Combinational 4-bit to active-low 7-segment decoder; 10..15 show blank.
module seg7_digit
  import referee_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (value <= 4'd9) seg = SEG_DIGIT[value];
  end

endmodule

// File: rtl/match_referee.sv
// Best-of-N match referee: scores round-win pulses, pauses the playfield
// between rounds and declares the winner. Optional macro REFEREE_BLINK_EN
// makes the winner's digit blink once the match is over.
module match_referee
  import referee_pkg::*;
#(
  parameter int WIN_SCORE    = 7,
  parameter int PAUSE_CYCLES = 8,
  parameter int BLINK_DIV    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       player1Win,
  input  logic       player2Win,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [6:0] hex0,
  output logic [6:0] hex5,
  output logic       playfieldReset,
  output logic       matchOver,
  output logic [1:0] matchWinner,
  output ref_state_t state_dbg
);

  localparam int CW = $clog2(PAUSE_CYCLES + 1);
  localparam logic [3:0]    WIN_S      = 4'(WIN_SCORE);
  localparam logic [CW-1:0] PAUSE_LOAD = CW'(PAUSE_CYCLES);

  ref_state_t    state, state_n;
  logic [3:0]    score1_n, score2_n;
  logic [CW-1:0] pause_cnt, pause_cnt_n;
  logic [1:0]    winner_n;
  logic [6:0]    seg1, seg2;
  logic          blink_off;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= PLAY;
      score1      <= '0;
      score2      <= '0;
      pause_cnt   <= '0;
      matchWinner <= WIN_NONE;
    end else begin
      state       <= state_n;
      score1      <= score1_n;
      score2      <= score2_n;
      pause_cnt   <= pause_cnt_n;
      matchWinner <= winner_n;
    end
  end

  always_comb begin
    state_n     = state;
    score1_n    = score1;
    score2_n    = score2;
    pause_cnt_n = pause_cnt;
    winner_n    = matchWinner;
    case (state)
      PLAY: begin
        // A simultaneous pair is a tied round: no points, but still restart.
        if (player1Win && player2Win) begin
          pause_cnt_n = PAUSE_LOAD;
          state_n     = PAUSE;
        end else if (player1Win) begin
          pause_cnt_n = PAUSE_LOAD;
          if (score1 < WIN_S) score1_n = score1 + 4'd1;
          if (score1_n == WIN_S) begin
            state_n  = OVER;
            winner_n = WIN_P1;
          end else begin
            state_n = PAUSE;
          end
        end else if (player2Win) begin
          pause_cnt_n = PAUSE_LOAD;
          if (score2 < WIN_S) score2_n = score2 + 4'd1;
          if (score2_n == WIN_S) begin
            state_n  = OVER;
            winner_n = WIN_P2;
          end else begin
            state_n = PAUSE;
          end
        end
      end
      PAUSE: begin
        if (pause_cnt <= CW'(1)) begin
          pause_cnt_n = '0;
          state_n     = PLAY;
        end else begin
          pause_cnt_n = pause_cnt - CW'(1);
        end
      end
      OVER:    state_n = OVER;
      default: state_n = PLAY;
    endcase
  end

`ifdef REFEREE_BLINK_EN
  logic [BLINK_DIV:0] blink_cnt;

  // Held at zero outside OVER, so the first OVER cycle shows the digit.
  always_ff @(posedge clk) begin
    if (reset || state != OVER) blink_cnt <= '0;
    else                        blink_cnt <= blink_cnt + 1'b1;
  end

  assign blink_off = (state == OVER) && blink_cnt[BLINK_DIV];
`else
  localparam int BLINK_DIV_UNUSED = BLINK_DIV;
  assign blink_off = 1'b0;
`endif

  seg7_digit u_seg_p1 (.value(score1), .seg(seg1));
  seg7_digit u_seg_p2 (.value(score2), .seg(seg2));

  assign hex0 = (blink_off && matchWinner == WIN_P1) ? SEG_BLANK : seg1;
  assign hex5 = (blink_off && matchWinner == WIN_P2) ? SEG_BLANK : seg2;

  assign playfieldReset = (state == PAUSE) || (state == OVER);
  assign matchOver      = (state == OVER);
  assign state_dbg      = state;

endmodule

// File: tb/tb_match_referee.sv
// Directed bench for match_referee: scoring, pauses, ties, reset, match end
// and (with REFEREE_BLINK_EN) the blinking winner digit.
module tb_match_referee;
  import referee_pkg::*;

`ifdef REFEREE_BLINK_EN
  localparam int BD = 2;
`else
  localparam int BD = 4;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       player1Win = 1'b0;
  logic       player2Win = 1'b0;
  logic [3:0] score1, score2;
  logic [6:0] hex0, hex5;
  logic       playfieldReset, matchOver;
  logic [1:0] matchWinner;
  ref_state_t state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [6:0] exp_q[$];

  match_referee #(.WIN_SCORE(7), .PAUSE_CYCLES(8), .BLINK_DIV(BD)) dut (
    .clk(clk), .reset(reset),
    .player1Win(player1Win), .player2Win(player2Win),
    .score1(score1), .score2(score2), .hex0(hex0), .hex5(hex5),
    .playfieldReset(playfieldReset), .matchOver(matchOver),
    .matchWinner(matchWinner), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic p1, input logic p2);
    player1Win = p1;
    player2Win = p2;
    tick();
    player1Win = 1'b0;
    player2Win = 1'b0;
  endtask

  task automatic wait_pause(output int n);
    n = 0;
    while (playfieldReset && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic do_reset(input logic p1);
    reset      = 1'b1;
    player1Win = p1;
    tick();
    reset      = 1'b0;
    player1Win = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_score1"}, 32'(score1), 32'd0);
    check({tag, "_score2"}, 32'(score2), 32'd0);
    check({tag, "_hex0"}, 32'(hex0), 32'h40);
    check({tag, "_hex5"}, 32'(hex5), 32'h40);
    check({tag, "_pfreset"}, 32'(playfieldReset), 32'd0);
    check({tag, "_over"}, 32'(matchOver), 32'd0);
    check({tag, "_winner"}, 32'(matchWinner), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'(PLAY));
  endtask

  initial begin
    int n;

    tick();
    tick();
    reset = 1'b0;
    check_reset_values("rst");

    // Single point for player 1 and a clean 8-cycle pause.
    pulse(1'b1, 1'b0);
    check("p1_score1", 32'(score1), 32'd1);
    check("p1_hex0", 32'(hex0), 32'h79);
    check("p1_pfreset", 32'(playfieldReset), 32'd1);
    check("p1_state", 32'(state_dbg), 32'(PAUSE));
    wait_pause(n);
    check("p1_pause_len", 32'(n), 32'd8);
    check("p1_back_play", 32'(state_dbg), 32'(PLAY));

    // Player 2 pulse injected mid-pause must be ignored.
    pulse(1'b1, 1'b0);
    check("p1b_score1", 32'(score1), 32'd2);
    n = 0;
    while (playfieldReset && n < 100) begin
      n++;
      player2Win = (n == 3);
      tick();
    end
    player2Win = 1'b0;
    check("ign_pause_len", 32'(n), 32'd8);
    check("ign_score2", 32'(score2), 32'd0);

    // Tied round: no points, still a full pause.
    pulse(1'b1, 1'b1);
    check("tie_score1", 32'(score1), 32'd2);
    check("tie_score2", 32'(score2), 32'd0);
    check("tie_pfreset", 32'(playfieldReset), 32'd1);
    wait_pause(n);
    check("tie_pause_len", 32'(n), 32'd8);

    // Reset mid-pause, with a simultaneous win pulse that must lose.
    pulse(1'b1, 1'b0);
    check("mid_score1", 32'(score1), 32'd3);
    check("mid_hex0", 32'(hex0), 32'h30);
    tick();
    tick();
    do_reset(1'b1);
    check_reset_values("midrst");

    // Player 2 takes the match with seven points.
    for (int i = 1; i <= 7; i++) begin
      pulse(1'b0, 1'b1);
      check($sformatf("p2_score_%0d", i), 32'(score2), 32'(i));
      if (i < 7) begin
        check($sformatf("p2_notover_%0d", i), 32'(matchOver), 32'd0);
        wait_pause(n);
        check($sformatf("p2_pause_%0d", i), 32'(n), 32'd8);
      end
    end
    check("p2_hex5", 32'(hex5), 32'h78);
    check("p2_over", 32'(matchOver), 32'd1);
    check("p2_winner", 32'(matchWinner), 32'(WIN_P2));
    check("p2_pfreset", 32'(playfieldReset), 32'd1);
    check("p2_state", 32'(state_dbg), 32'(OVER));
    for (int i = 0; i < 12; i++) tick();
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    check("over_score1", 32'(score1), 32'd0);
    check("over_score2", 32'(score2), 32'd7);
    check("over_held", 32'(playfieldReset & matchOver), 32'd1);
    check("over_winner_held", 32'(matchWinner), 32'(WIN_P2));

    // Player 1 takes a fresh match; watch the winner digit in OVER.
    do_reset(1'b0);
    check_reset_values("rst2");
    for (int i = 1; i <= 7; i++) begin
      pulse(1'b1, 1'b0);
      if (i < 7) wait_pause(n);
    end
    check("p1m_score1", 32'(score1), 32'd7);
    check("p1m_winner", 32'(matchWinner), 32'(WIN_P1));
    check("p1m_over", 32'(matchOver), 32'd1);
    for (int k = 0; k < 16; k++) begin
`ifdef REFEREE_BLINK_EN
      exp_q.push_back(((k / 4) % 2 == 1) ? 7'h7F : 7'h78);
`else
      exp_q.push_back(7'h78);
`endif
    end
    for (int k = 0; k < 16; k++) begin
      check($sformatf("win_hex0_%0d", k), 32'(hex0), 32'(exp_q.pop_front()));
      check($sformatf("lose_hex5_%0d", k), 32'(hex5), 32'h40);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/match_referee.md
# match_referee

Consumer end of the playfield's round-win interface. It receives the single-cycle `player1Win`/`player2Win` pulses produced by round-end detection and keeps a best-of-N match score for each player. Between rounds it holds the playfield in reset for a fixed pause, and it declares the match winner. It drives the two score digits (active-low 7-segment) that currently come from the free-running per-player counters.

## Interface
Parameters:
- `WIN_SCORE`, 7: points needed to win the match; legal range 1..9.
- `PAUSE_CYCLES`, 8: cycles `playfieldReset` is held after a scored round; legal range ≥1.
- `BLINK_DIV`, 4: log2 of the blink half-period in cycles. Used only with `REFEREE_BLINK_EN`.

Ports (one clock; `reset` is synchronous and active-high):
- `clk`: input, 1 bit. System clock; all state updates on its rising edge.
- `reset`: input, 1 bit. Synchronous, active-high; clears the entire match.
- `player1Win`: input, 1 bit. One-cycle pulse; player 1 (left, HEX0) won the round.
- `player2Win`: input, 1 bit. One-cycle pulse; player 2 (right, HEX5) won the round.
- `score1`: output, 4 bits. Player 1 points, binary.
- `score2`: output, 4 bits. Player 2 points, binary.
- `hex0`: output, 7 bits. Active-low segments {g..a} showing `score1`.
- `hex5`: output, 7 bits. Active-low segments showing `score2`.
- `playfieldReset`: output, 1 bit. High while the playfield must be held cleared.
- `matchOver`: output, 1 bit. High once a player reaches `WIN_SCORE`.
- `matchWinner`: output, 2 bits. 00 = none, 01 = player 1, 10 = player 2.

## Operation
- States: PLAY, PAUSE, OVER.
- Reset values: state PLAY, `score1`/`score2` 0, `hex0`/`hex5` = 7'b1000000 ("0"), `playfieldReset` 0, `matchOver` 0, `matchWinner` 00. Pause counter is 0.
- PLAY:
  - Exactly one win pulse: increment that player's score and load the pause counter with `PAUSE_CYCLES`.
  - If the new score equals `WIN_SCORE`, go to OVER. Otherwise go to PAUSE.
- PLAY, both pulses in the same cycle:
  - Tie; neither score changes.
  - Go to PAUSE anyway, so the playfield still restarts.
- PAUSE:
  - Decrement the counter every cycle.
  - When it reaches 0, return to PLAY.
  - All win pulses are ignored.
- OVER:
  - Terminal state; left only by `reset`.
  - Win pulses are ignored and scores freeze.
- `playfieldReset` = (state is PAUSE) or (state is OVER).
- `matchOver` = (state is OVER).
- `matchWinner` is set on entry to OVER and otherwise held.
- Arithmetic:
  - Scores are 4-bit and saturate at `WIN_SCORE`; they never wrap.
  - The pause counter width is $clog2(PAUSE_CYCLES+1).
- 7-segment decode covers digits 0..9. Values 10..15 are unreachable; if they occur, show blank (7'h7F).
- `reset` asserted in any state, including mid-pause, returns everything to reset values on the next edge. `reset` has priority over any win pulse in the same cycle.

## Timing
- A win pulse sampled at edge N:
  - The score and its hex digit update at edge N (visible in cycle N+1).
  - `playfieldReset` is high from cycle N+1 through cycle N+`PAUSE_CYCLES`, then low again. PLAY resumes at edge N+`PAUSE_CYCLES`.
- Scoring the final point:
  - `matchOver`, `matchWinner` and `playfieldReset` rise in cycle N+1.
  - They stay high until `reset`.
- Outputs are all registered or decoded from registered state. There is no combinational path from the win inputs to any output.

## Configuration
- `REFEREE_BLINK_EN`, compiled in:
  - In OVER, the winner's digit blinks: it alternates between its score and blank (7'h7F) every 2^`BLINK_DIV` cycles.
  - The blink starts with the digit shown, in the first OVER cycle.
  - The loser's digit stays steady.
  - Blink counter resets to 0 on `reset` and on entry to OVER.
- Compiled out: no blink counter exists, and the winner's digit is shown steadily in OVER.

## Structure
- `referee_pkg` holds:
  - the state enum `ref_state_t` {PLAY, PAUSE, OVER};
  - the winner codes `WIN_NONE`/`WIN_P1`/`WIN_P2`;
  - the segment constants `SEG_BLANK` and `SEG_DIGIT[0:9]`.
- One sub-module, `seg7_digit`: purely combinational 4-bit to active-low 7-segment decoder. It is instantiated twice, once for `hex0` and once for `hex5`.

## Test plan
- Reset, then a `player1Win` pulse → `score1` = 1, `hex0` = 7'b1111001. `playfieldReset` is high for exactly 8 cycles, then low.
- `player2Win` pulse during PAUSE → ignored; `score2` stays 0 and the pause length is unchanged.
- `player1Win` and `player2Win` high in the same cycle in PLAY → both scores unchanged. `playfieldReset` is still high for 8 cycles.
- 7 spaced `player2Win` pulses → after the 7th: `score2` = 7, `matchOver` = 1, `matchWinner` = 10, `playfieldReset` held high. A further `player1Win` leaves `score1` unchanged.
- `reset` asserted mid-pause (`score1` = 3) → next cycle: all outputs at reset values and `playfieldReset` = 0.
- With `REFEREE_BLINK_EN`, `BLINK_DIV` = 2: after player 1 wins, `hex0` alternates between 7'b1111000 ("7") and 7'h7F every 4 cycles, while `hex5` stays steady.
